// File: rtl/wb_initiator_pkg.sv
// Shared types for the single-transfer Wishbone initiator: response status codes
// and FSM state encoding.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_ERR     = 2'd1,
        STATUS_RETRY   = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BACKOFF,
        S_RESP
    } state_t;

endpackage

// File: rtl/wb_initiator.sv
// Single-transfer Wishbone pipelined-mode initiator: one bus cycle per accepted
// command, with bounded retry, response timeout and a held response stream.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [7:0]            cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [7:0]            rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [7:0]            dat_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  rty_i,
    input  logic                  stall_i,
    input  logic [7:0]            dat_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // A zero-width retry counter is illegal, so keep at least one bit.
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    state_t                  state_q, state_d;
    status_t                 status_q, status_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]              dat_q, dat_d;
    logic [7:0]              rsp_dat_q, rsp_dat_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    tmo_d   = '0;
                    retry_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // err > rty > ack, and any termination beats the timeout.
                if (err_i) begin
                    status_d  = STATUS_ERR;
                    rsp_dat_d = '0;
                    state_d   = S_RESP;
                end else if (rty_i) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_BACKOFF;
                    end else begin
                        status_d  = STATUS_RETRY;
                        rsp_dat_d = '0;
                        state_d   = S_RESP;
                    end
                end else if (ack_i) begin
                    status_d  = STATUS_OK;
                    rsp_dat_d = we_q ? 8'h00 : dat_i;
                    state_d   = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    status_d  = STATUS_TIMEOUT;
                    rsp_dat_d = '0;
                    state_d   = S_RESP;
                end else if (state_q == S_REQ && !stall_i) begin
                    state_d = S_WAIT;
                end
            end
            S_BACKOFF: begin
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered images of the next state.
        cmd_ready_d = (state_d == S_IDLE);
        cyc_d       = (state_d == S_REQ) || (state_d == S_WAIT);
        stb_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            status_q    <= STATUS_OK;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_dat_q   <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_dat_q   <= rsp_dat_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = stb_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = status_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a planned Wishbone responder, a transaction-level
// model that predicts each command's bus waveform and response, and a per-cycle checker.
module tb_wb_initiator;

    localparam int TMO  = 8;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_we_i = 1'b0;
    logic [1:0] cmd_adr_i = '0;
    logic [7:0] cmd_dat_i = '0;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [7:0] rsp_dat_o;
    logic [1:0] rsp_status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0, stall_i = 1'b0;
    logic [7:0] dat_i = '0;

    wb_initiator #(.ADDR_WIDTH(2), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-issue plan for the current command; final kind 0=ack 1=err 2=err+ack 3=silent
    int pl_stall [8];
    int pl_lat   [8];
    int pl_nrty;
    int pl_final;
    int seq = 0;

    logic [7:0] rmem [4];
    logic [7:0] mmem [4];

    // Observations latched when a response is consumed
    int last_lat, last_stb, last_cyc, last_vld;
    logic [7:0] last_dat;
    logic [1:0] last_status;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responder: follows the plan for whichever command is in flight.
    initial begin
        int my_seq = 0, issue = -1, stall_left = 0, lat_left = 0, ix;
        bit prev_cyc = 0, done = 0;
        forever begin
            @(posedge clk); #1;
            ack_i = 0; err_i = 0; rty_i = 0; stall_i = 0; dat_i = 8'($urandom);
            if (my_seq != seq) begin my_seq = seq; issue = -1; end
            if (rst_i || !cyc_o) begin
                prev_cyc = 0;
                ack_i = ($urandom_range(0, 3) == 0);
                err_i = ($urandom_range(0, 5) == 0);
                rty_i = ($urandom_range(0, 5) == 0);
                stall_i = $urandom_range(0, 1) == 1;
            end else begin
                if (!prev_cyc) begin
                    issue = (issue < 7) ? issue + 1 : 7;
                    stall_left = pl_stall[issue];
                    lat_left = pl_lat[issue];
                    done = 0;
                end
                prev_cyc = 1;
                ix = (issue < 0) ? 0 : issue;
                if (stb_o) begin
                    if (stall_left > 0) begin stall_i = 1; stall_left--; end
                end else if (!done) begin
                    if (lat_left > 0) lat_left--;
                    else begin
                        done = 1;
                        if (ix < pl_nrty) rty_i = 1;
                        else case (pl_final)
                            0: begin
                                ack_i = 1;
                                if (we_o) rmem[adr_o] = dat_o;
                                else dat_i = rmem[adr_o];
                            end
                            1: err_i = 1;
                            2: begin err_i = 1; ack_i = 1; dat_i = 8'hE7; end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Model + per-cycle compare.
    initial begin
        bit started = 0, rst_edge = 0, busy = 0;
        bit exp_cyc [128];
        bit exp_stb [128];
        int t = 0, exp_lat = 0, out, d, stb_cnt, cyc_cnt, vld_cnt, lat_obs;
        logic e_we;
        logic [1:0] e_adr, e_status;
        logic [7:0] e_dat, e_rdat;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cmd_ready", 64'(cmd_ready_o), 64'(!rst_edge && !busy));
                if (rst_edge) begin
                    chk("reset_vals", 64'({cyc_o, stb_o, we_o, rsp_valid_o, adr_o, dat_o, rsp_dat_o, rsp_status_o}), 64'(0));
                end else if (!busy) begin
                    chk("bus_idle", 64'({cyc_o, stb_o, rsp_valid_o}), 64'(0));
                end else begin
                    t++;
                    stb_cnt += int'(stb_o);
                    cyc_cnt += int'(cyc_o);
                    if (rsp_valid_o) begin
                        vld_cnt++;
                        if (lat_obs == 0) lat_obs = t;
                    end
                    if (t < exp_lat) begin
                        chk("cyc_stb", 64'({cyc_o, stb_o, rsp_valid_o}),
                            64'({exp_cyc[t < 128 ? t : 127], exp_stb[t < 128 ? t : 127], 1'b0}));
                        if (cyc_o) chk("bus_cmd", 64'({we_o, adr_o, dat_o}), 64'({e_we, e_adr, e_dat}));
                    end else begin
                        chk("rsp", 64'({cyc_o, stb_o, rsp_valid_o, rsp_dat_o, rsp_status_o}),
                            64'({2'b00, 1'b1, e_rdat, e_status}));
                    end
                end
            end
            // Predict what the coming edge does.
            if (rst_i) begin
                busy = 0;
            end else if (busy && rsp_valid_o && rsp_ready_i) begin
                busy = 0;
                if (e_status == 2'd0 && e_we) mmem[e_adr] = e_dat;
                last_lat = lat_obs; last_stb = stb_cnt; last_cyc = cyc_cnt; last_vld = vld_cnt;
                last_dat = rsp_dat_o; last_status = rsp_status_o;
            end else if (started && !busy && cmd_valid_i && cmd_ready_o) begin
                busy = 1; t = 0; stb_cnt = 0; cyc_cnt = 0; vld_cnt = 0; lat_obs = 0;
                e_we = cmd_we_i; e_adr = cmd_adr_i; e_dat = cmd_dat_i;
                for (int k = 0; k < 128; k++) begin exp_cyc[k] = 0; exp_stb[k] = 0; end
                exp_lat = 1; out = -1;
                for (int i = 0; i < 8 && out < 0; i++) begin
                    bit silent;
                    silent = (i >= pl_nrty) && (pl_final == 3);
                    d = pl_stall[i] + pl_lat[i] + 2;
                    if (silent || d > TMO) d = TMO;
                    for (int k = 0; k < d; k++) begin
                        exp_cyc[exp_lat + k] = 1;
                        exp_stb[exp_lat + k] = (k <= pl_stall[i]);
                    end
                    exp_lat += d;
                    if (silent || pl_stall[i] + pl_lat[i] + 2 > TMO) out = 3;
                    else if (i < pl_nrty) begin
                        if (i < MAXR) exp_lat += 1;
                        else out = 2;
                    end else out = (pl_final == 0) ? 0 : 1;
                end
                e_status = 2'(out);
                e_rdat = (out == 0 && !e_we) ? mmem[e_adr] : 8'h00;
            end
            rst_edge = rst_i;
            if (rst_i) started = 1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_plan(input int nrty, input int fin, input int stall, input int lat);
        pl_nrty = nrty; pl_final = fin;
        for (int i = 0; i < 8; i++) begin pl_stall[i] = stall; pl_lat[i] = lat; end
    endtask

    task automatic present(input logic we, input logic [1:0] adr, input logic [7:0] dat);
        int n = 0;
        seq++;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_valid_i = 1;
        while (!cmd_ready_o && n < 50) begin step(); n++; end
        chk("accept", 64'(cmd_ready_o), 64'(1));
        step();
        cmd_valid_i = 0;
        cmd_we_i = 1'($urandom); cmd_adr_i = 2'($urandom); cmd_dat_i = 8'($urandom);
    endtask

    task automatic finish_rsp(input int rdy_wait);
        int n = 0;
        while (!rsp_valid_o && n < 200) begin step(); n++; end
        chk("rsp_arrives", 64'(rsp_valid_o), 64'(1));
        repeat (rdy_wait) step();
        rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rmem[i] = 8'($urandom);
            mmem[i] = rmem[i];
        end
        rmem[2] = 8'hA5; mmem[2] = 8'hA5;
        set_plan(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        step();

        // Zero-wait read
        present(1'b0, 2'd2, 8'h00); finish_rsp(0);
        chk("rd_lat", 64'(last_lat), 64'(3));
        chk("rd_dat", 64'(last_dat), 64'(8'hA5));
        chk("rd_status", 64'(last_status), 64'(0));
        chk("rd_stb", 64'(last_stb), 64'(1));

        // Write then read back
        present(1'b1, 2'd1, 8'h3C); finish_rsp(0);
        chk("wr_status", 64'({last_status, last_dat}), 64'(0));
        present(1'b0, 2'd1, 8'h00); finish_rsp(1);
        chk("rdback_dat", 64'(last_dat), 64'(8'h3C));

        // Stall for four cycles
        set_plan(0, 0, 4, 0);
        present(1'b0, 2'd1, 8'h00); finish_rsp(0);
        chk("stall_stb", 64'(last_stb), 64'(5));
        chk("stall_lat", 64'(last_lat), 64'(7));
        chk("stall_status", 64'(last_status), 64'(0));

        // Retry on every attempt
        set_plan(8, 0, 0, 0);
        present(1'b1, 2'd3, 8'h77); finish_rsp(0);
        chk("rty_stb", 64'(last_stb), 64'(4));
        chk("rty_cyc", 64'(last_cyc), 64'(8));
        chk("rty_lat", 64'(last_lat), 64'(12));
        chk("rty_status", 64'(last_status), 64'(2));

        // Silent responder
        set_plan(0, 3, 0, 0);
        present(1'b0, 2'd2, 8'h00); finish_rsp(0);
        chk("tmo_cyc", 64'(last_cyc), 64'(8));
        chk("tmo_lat", 64'(last_lat), 64'(9));
        chk("tmo_rsp", 64'({last_status, last_dat}), 64'({2'd3, 8'h00}));

        // err with ack, response stalled by consumer
        set_plan(0, 2, 0, 0);
        present(1'b0, 2'd2, 8'h00); finish_rsp(5);
        chk("errack_status", 64'({last_status, last_dat}), 64'({2'd1, 8'h00}));
        chk("errack_hold", 64'(last_vld), 64'(6));

        // Reset while waiting for termination
        set_plan(0, 3, 0, 0);
        present(1'b0, 2'd0, 8'h00);
        step();
        chk("in_wait", 64'({cyc_o, stb_o}), 64'(2'b10));
        rst_i = 1;
        step();
        rst_i = 0;
        chk("rst_bus_idle", 64'({cyc_o, stb_o, rsp_valid_o}), 64'(0));
        repeat (15) step();
        chk("rst_no_rsp", 64'(rsp_valid_o), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 120; c++) begin
            pl_nrty = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            pl_final = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) begin
                pl_stall[i] = $urandom_range(0, 4);
                pl_lat[i] = $urandom_range(0, 3);
            end
            repeat ($urandom_range(0, 2)) step();
            present(1'($urandom), 2'($urandom), 8'($urandom));
            finish_rsp($urandom_range(0, 3));
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
